// File: rtl/ext_clock_select_ctrl.sv
// Measures the external 10 MHz reference and sequences the reference mux and PLL reset between internal and external.
// Window results appear the cycle after each gate wrap; there is no backpressure, only level and pulse outputs.
module ext_clock_select_ctrl #(
  parameter int GATE_CYCLES    = 25000,
  parameter int EXPECTED_COUNT = 1000,
  parameter int TOLERANCE      = 10,
  parameter int GOOD_WINDOWS   = 16,
  parameter int BAD_WINDOWS    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_clk_toggle,
  input  logic             pll_locked,
  input  logic             allow_ext,
  output logic             clk_sel,
  output logic             pll_rst,
  output logic             ext_clock_selected,
  output logic [CNT_W-1:0] ext_count,
  output logic             ext_count_valid,
  output logic             ext_good
);

  localparam int GW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GRW = $clog2(GOOD_WINDOWS + 1);
  localparam int BRW = $clog2(BAD_WINDOWS + 1);
  localparam int PW  = $clog2(PLL_RST_CYCLES + 1);
  localparam int LW  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXPECTED_COUNT);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOLERANCE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [GRW-1:0]   GOOD_C    = GRW'(GOOD_WINDOWS);
  localparam logic [BRW-1:0]   BAD_C     = BRW'(BAD_WINDOWS);
  localparam logic [PW-1:0]    PULSE_C   = PW'(PLL_RST_CYCLES);
  localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_INT,
    ST_SW_EXT,
    ST_EXT,
    ST_SW_INT
  } state_t;

  // Synchronizers; the third ext flop gives the previous level for edge detection.
  logic ext_s1, ext_s2, ext_s3;
  logic lock_s1, lock_s2;
  logic edge_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_s1  <= 1'b0;
      ext_s2  <= 1'b0;
      ext_s3  <= 1'b0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      ext_s1  <= ext_clk_toggle;
      ext_s2  <= ext_s1;
      ext_s3  <= ext_s2;
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
    end
  end

  assign edge_det = ext_s2 ^ ext_s3;

  logic [GW-1:0]    gate_idx;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_diff;
  logic             win_close;
  logic             win_good;

  assign win_close = (gate_idx == GATE_LAST);

  // win_cnt folds in the current cycle's edge so the closing cycle is never lost.
  always_comb begin
    win_cnt = edge_cnt;
    if (edge_det && (edge_cnt != CNT_MAX)) begin
      win_cnt = edge_cnt + CNT_W'(1);
    end
    if (win_cnt >= EXP_C) begin
      win_diff = win_cnt - EXP_C;
    end else begin
      win_diff = EXP_C - win_cnt;
    end
    win_good = (win_diff <= TOL_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_idx        <= '0;
      edge_cnt        <= '0;
      ext_count       <= '0;
      ext_count_valid <= 1'b0;
      ext_good        <= 1'b0;
    end else begin
      ext_count_valid <= 1'b0;
      if (win_close) begin
        gate_idx        <= '0;
        edge_cnt        <= '0;
        ext_count       <= win_cnt;
        ext_count_valid <= 1'b1;
        ext_good        <= win_good;
      end else begin
        gate_idx <= gate_idx + GW'(1);
        edge_cnt <= win_cnt;
      end
    end
  end

  logic [GRW-1:0] good_run;
  logic [BRW-1:0] bad_run;
  logic           enter_sw;

  always_ff @(posedge clk) begin
    if (rst) begin
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      if (win_close) begin
        if (win_good) begin
          if (good_run < GOOD_C) good_run <= good_run + GRW'(1);
          bad_run <= '0;
        end else begin
          good_run <= '0;
          if (bad_run < BAD_C) bad_run <= bad_run + BRW'(1);
        end
      end
      // Any switchover invalidates the current qualification run.
      if (enter_sw) good_run <= '0;
    end
  end

  state_t         state, state_nxt;
  logic [PW-1:0]  ph_cnt, ph_nxt;
  logic [LW-1:0]  wait_cnt, wait_nxt;
  logic           pulse_done;

  assign pulse_done = (ph_cnt == PULSE_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SW_INT;
      ph_cnt   <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ph_cnt   <= ph_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    ph_nxt             = ph_cnt;
    wait_nxt           = wait_cnt;
    enter_sw           = 1'b0;
    clk_sel            = 1'b0;
    pll_rst            = 1'b0;
    ext_clock_selected = 1'b0;

    case (state)
      ST_INT: begin
        if (allow_ext && (good_run >= GOOD_C)) begin
          state_nxt = ST_SW_EXT;
          enter_sw  = 1'b1;
        end
      end

      ST_SW_EXT: begin
        clk_sel = 1'b1;
        if (!pulse_done) begin
          pll_rst = 1'b1;
          ph_nxt  = ph_cnt + PW'(1);
        end else if (!allow_ext) begin
          state_nxt = ST_SW_INT;
          enter_sw  = 1'b1;
        end else if (lock_s2) begin
          state_nxt = ST_EXT;
        end else if (wait_cnt == LOCK_LAST) begin
          state_nxt = ST_SW_INT;
          enter_sw  = 1'b1;
        end else begin
          wait_nxt = wait_cnt + LW'(1);
        end
      end

      ST_EXT: begin
        clk_sel = 1'b1;
        if ((bad_run >= BAD_C) || !allow_ext || !lock_s2) begin
          state_nxt = ST_SW_INT;
          enter_sw  = 1'b1;
        end else begin
          ext_clock_selected = 1'b1;
        end
      end

      ST_SW_INT: begin
        if (!pulse_done) begin
          pll_rst = 1'b1;
          ph_nxt  = ph_cnt + PW'(1);
        end else if (lock_s2) begin
          state_nxt = ST_INT;
        end else if (wait_cnt == LOCK_LAST) begin
          // PLL never locked on internal: restart the reset pulse.
          state_nxt = ST_SW_INT;
          enter_sw  = 1'b1;
        end else begin
          wait_nxt = wait_cnt + LW'(1);
        end
      end

      default: begin
        state_nxt = ST_SW_INT;
        enter_sw  = 1'b1;
      end
    endcase

    if (enter_sw) begin
      ph_nxt   = '0;
      wait_nxt = '0;
    end
  end

endmodule
